// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: triggers, decimates and writes packed
// sample sets from the SYZYGY deserialiser into the sample FIFO.
//
// Ports:
//   adc_data_clk, reset    clock, synchronous active-high reset
//   adc_data, adc_valid    packed channel samples and their strobe
//   arm, abort             start a capture / return to IDLE
//   trig_mode, sw_trig     trigger source and software trigger
//   trig_level             signed level-trigger threshold
//   decim                  keep 1 of every decim+1 sample sets
//   capture_len            words per capture, 0 = continuous
//   fifo_prog_full         FIFO cannot accept a burst
//   fifo_busy              FIFO reset in progress
//   fifo_din, fifo_wr_en   FIFO write port
//   state, done            capture state and completion level
//   overflow               sticky, a kept sample was dropped
//   words_written          writes in the current capture
module adc_capture_ctrl #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int TRIG_CH  = 0
) (
    input  logic                       adc_data_clk,
    input  logic                       reset,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic                       adc_valid,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 trig_mode,
    input  logic                       sw_trig,
    input  logic [SAMPLE_W-1:0]        trig_level,
    input  logic [15:0]                decim,
    input  logic [31:0]                capture_len,
    input  logic                       fifo_prog_full,
    input  logic                       fifo_busy,
    output logic [NUM_CH*SAMPLE_W-1:0] fifo_din,
    output logic                       fifo_wr_en,
    output logic [1:0]                 state,
    output logic                       done,
    output logic                       overflow,
    output logic [31:0]                words_written
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t st_q, st_d;

    logic [1:0]                 mode_q;
    logic [15:0]                decim_q;
    logic [31:0]                len_q;
    logic signed [SAMPLE_W-1:0] lvl_q;
    logic signed [SAMPLE_W-1:0] prev_q;
    logic                       prev_vld_q;
    logic                       sw_pend_q;
    logic [15:0]                dcnt_q;

    logic signed [SAMPLE_W-1:0] cur;
    logic                       trig;
    logic                       fire;
    logic                       keep;
    logic                       blocked;
    logic                       wr;
    logic                       drop;
    logic                       last;
    logic                       arm_ok;
    logic [31:0]                ww_inc;

    assign cur = adc_data[TRIG_CH*SAMPLE_W +: SAMPLE_W];

    always_comb begin
        trig = 1'b0;
        case (mode_q)
            2'd0: trig = 1'b1;
            2'd1: trig = sw_pend_q | sw_trig;
            2'd2: trig = prev_vld_q
                       && (prev_q < lvl_q)
                       && (lvl_q <= cur);
            2'd3: trig = prev_vld_q
                       && (prev_q >= lvl_q)
                       && (lvl_q > cur);
            default: trig = 1'b0;
        endcase
    end

    always_comb begin
        fire    = (st_q == S_ARMED) && adc_valid && trig;
        // The triggering set is always kept; in CAPTURE the
        // decimation counter decides.
        keep    = fire
                || ((st_q == S_CAPT) && adc_valid
                    && (dcnt_q == 16'd0));
        blocked = fifo_prog_full | fifo_busy;
        wr      = keep && !blocked && !abort;
        drop    = keep && blocked && !abort;
        ww_inc  = words_written + 32'd1;
        last    = wr && (len_q != 32'd0) && (ww_inc == len_q);
        arm_ok  = arm && ((st_q == S_IDLE) || (st_q == S_DONE));

        st_d = st_q;
        if (abort) begin
            st_d = S_IDLE;
        end else if (arm_ok) begin
            st_d = S_ARMED;
        end else if (last) begin
            st_d = S_DONE;
        end else if (fire) begin
            st_d = S_CAPT;
        end
    end

    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            st_q          <= S_IDLE;
            mode_q        <= 2'd0;
            decim_q       <= 16'd0;
            len_q         <= 32'd0;
            lvl_q         <= '0;
            prev_q        <= '0;
            prev_vld_q    <= 1'b0;
            sw_pend_q     <= 1'b0;
            dcnt_q        <= 16'd0;
            fifo_din      <= '0;
            fifo_wr_en    <= 1'b0;
            overflow      <= 1'b0;
            words_written <= 32'd0;
        end else begin
            st_q       <= st_d;
            fifo_wr_en <= wr;
            if (wr) begin
                fifo_din <= adc_data;
            end

            if (arm_ok && !abort) begin
                mode_q        <= trig_mode;
                decim_q       <= decim;
                len_q         <= capture_len;
                lvl_q         <= trig_level;
                prev_vld_q    <= 1'b0;
                overflow      <= 1'b0;
                words_written <= 32'd0;
            end else begin
                if (wr) begin
                    words_written <= ww_inc;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                if ((st_q == S_ARMED) && adc_valid) begin
                    prev_q     <= cur;
                    prev_vld_q <= 1'b1;
                end
            end

            // Pending software trigger lives only while ARMED.
            sw_pend_q <= (st_q == S_ARMED)
                      && (st_d == S_ARMED)
                      && (sw_pend_q || sw_trig);

            if (fire) begin
                dcnt_q <= decim_q;
            end else if ((st_q == S_CAPT) && adc_valid) begin
                if (dcnt_q == 16'd0) begin
                    dcnt_q <= decim_q;
                end else begin
                    dcnt_q <= dcnt_q - 16'd1;
                end
            end
        end
    end

    assign state = st_q;
    assign done  = (st_q == S_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl
// (two channels, 16-bit samples, level trigger on ch0).
module tb_adc_capture_ctrl;

    logic        adc_data_clk = 1'b0;
    logic        reset;
    logic [31:0] adc_data;
    logic        adc_valid;
    logic        arm;
    logic        abort;
    logic [1:0]  trig_mode;
    logic        sw_trig;
    logic [15:0] trig_level;
    logic [15:0] decim;
    logic [31:0] capture_len;
    logic        fifo_prog_full;
    logic        fifo_busy;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic [1:0]  state;
    logic        done;
    logic        overflow;
    logic [31:0] words_written;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wq[$];
    logic        wd[$];

    always #5 adc_data_clk = ~adc_data_clk;

    adc_capture_ctrl #(
        .NUM_CH   (2),
        .SAMPLE_W (16),
        .TRIG_CH  (0)
    ) dut (
        .adc_data_clk   (adc_data_clk),
        .reset          (reset),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .arm            (arm),
        .abort          (abort),
        .trig_mode      (trig_mode),
        .sw_trig        (sw_trig),
        .trig_level     (trig_level),
        .decim          (decim),
        .capture_len    (capture_len),
        .fifo_prog_full (fifo_prog_full),
        .fifo_busy      (fifo_busy),
        .fifo_din       (fifo_din),
        .fifo_wr_en     (fifo_wr_en),
        .state          (state),
        .done           (done),
        .overflow       (overflow),
        .words_written  (words_written)
    );

    // Record every write strobe with the done level beside it.
    always @(negedge adc_data_clk) begin
        if (fifo_wr_en === 1'b1) begin
            wq.push_back(fifo_din);
            wd.push_back(done);
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int v);
        logic [15:0] a;
        a = 16'(v);
        return {a + 16'h1000, a};
    endfunction

    function automatic logic [31:0] qw(input int k);
        if (k < wq.size()) return wq[k];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic qd(input int k);
        if (k < wd.size()) return wd[k];
        return 1'bx;
    endfunction

    task automatic tick;
        @(posedge adc_data_clk);
        #1;
    endtask

    task automatic smp(input int v);
        adc_valid = 1'b1;
        adc_data  = word(v);
        tick();
    endtask

    task automatic idle_cyc;
        adc_valid = 1'b0;
        tick();
    endtask

    task automatic do_arm(input logic [1:0] m,
                          input int dec,
                          input int len,
                          input int lvl);
        trig_mode   = m;
        decim       = 16'(dec);
        capture_len = 32'(len);
        trig_level  = 16'(lvl);
        arm         = 1'b1;
        adc_valid   = 1'b1;
        adc_data    = word(50);
        tick();
        arm       = 1'b0;
        adc_valid = 1'b0;
        wq.delete();
        wd.delete();
    endtask

    initial begin
        reset          = 1'b1;
        adc_data       = '0;
        adc_valid      = 1'b0;
        arm            = 1'b0;
        abort          = 1'b0;
        trig_mode      = 2'd0;
        sw_trig        = 1'b0;
        trig_level     = '0;
        decim          = '0;
        capture_len    = '0;
        fifo_prog_full = 1'b0;
        fifo_busy      = 1'b0;
        repeat (3) tick();

        check("rst_state", state, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ww", words_written, 0);
        reset = 1'b0;
        idle_cyc();

        // Immediate capture, 8 words.
        do_arm(2'd0, 0, 8, 0);
        check("imm_armed", state, 1);
        for (int i = 0; i < 8; i++) smp(100 + i);
        check("imm_last_wr", fifo_wr_en, 1);
        check("imm_done", done, 1);
        check("imm_state", state, 3);
        check("imm_ww", words_written, 8);
        smp(108);
        check("imm_no_more", fifo_wr_en, 0);
        smp(109);
        check("imm_count", wq.size(), 8);
        for (int k = 0; k < 8; k++)
            check("imm_data", qw(k), word(100 + k));
        check("imm_done6", qd(6), 0);
        check("imm_done7", qd(7), 1);

        // Decimation by 4.
        do_arm(2'd0, 3, 4, 0);
        for (int i = 0; i < 20; i++) smp(i);
        check("dec_count", wq.size(), 4);
        for (int k = 0; k < 4; k++)
            check("dec_data", qw(k), word(4 * k));
        check("dec_ww", words_written, 4);
        check("dec_done", done, 1);

        // Rising level crossing.
        do_arm(2'd2, 0, 2, 100);
        smp(90); smp(99); smp(100);
        smp(120); smp(130); idle_cyc();
        check("rise_count", wq.size(), 2);
        check("rise_d0", qw(0), word(100));
        check("rise_d1", qw(1), word(120));

        // Starts above level: needs a drop and re-cross.
        do_arm(2'd2, 0, 2, 100);
        smp(150); smp(120); smp(100); smp(90); smp(95);
        check("rise2_armed", state, 1);
        smp(110); smp(111); smp(112); idle_cyc();
        check("rise2_count", wq.size(), 2);
        check("rise2_d0", qw(0), word(110));
        check("rise2_d1", qw(1), word(111));

        // Falling level crossing.
        do_arm(2'd3, 0, 2, 100);
        smp(50); smp(120); smp(100);
        smp(99); smp(80); smp(70); idle_cyc();
        check("fall_count", wq.size(), 2);
        check("fall_d0", qw(0), word(99));
        check("fall_d1", qw(1), word(80));

        // Backpressure for three kept samples.
        do_arm(2'd0, 0, 10, 0);
        for (int i = 0; i < 16; i++) begin
            fifo_prog_full = (i >= 3 && i <= 5);
            smp(200 + i);
        end
        fifo_prog_full = 1'b0;
        idle_cyc();
        check("bp_ovf", overflow, 1);
        check("bp_count", wq.size(), 10);
        check("bp_d2", qw(2), word(202));
        check("bp_d3", qw(3), word(206));
        check("bp_d9", qw(9), word(212));
        check("bp_ww", words_written, 10);
        check("bp_done", done, 1);

        // Abort after five writes of a continuous capture.
        do_arm(2'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) smp(i);
        check("ab_5th_wr", fifo_wr_en, 1);
        abort = 1'b1;
        smp(5);
        abort = 1'b0;
        check("ab_state", state, 0);
        check("ab_wr_en", fifo_wr_en, 0);
        check("ab_done", done, 0);
        smp(6); smp(7); smp(8);
        check("ab_count", wq.size(), 5);
        check("ab_ww", words_written, 5);

        // arm and abort together.
        arm   = 1'b1;
        abort = 1'b1;
        smp(9);
        arm   = 1'b0;
        abort = 1'b0;
        check("armab_state", state, 0);
        check("armab_ww", words_written, 5);
        smp(10);
        check("armab_wr_en", fifo_wr_en, 0);

        // arm during CAPTURE is ignored.
        do_arm(2'd0, 0, 0, 0);
        smp(0); smp(1); smp(2);
        check("armcap_ww3", words_written, 3);
        arm   = 1'b1;
        decim = 16'd5;
        smp(3);
        arm = 1'b0;
        check("armcap_state", state, 2);
        check("armcap_ww4", words_written, 4);
        smp(4);
        check("armcap_ww5", words_written, 5);
        abort = 1'b1;
        idle_cyc();
        abort = 1'b0;

        // Software trigger without a valid sample.
        do_arm(2'd1, 0, 2, 0);
        smp(10); smp(11);
        check("sw_wait", state, 1);
        sw_trig = 1'b1;
        idle_cyc();
        sw_trig = 1'b0;
        check("sw_pend", state, 1);
        smp(77);
        check("sw_capt", state, 2);
        check("sw_wr", fifo_wr_en, 1);
        smp(78);
        check("sw_done", done, 1);
        idle_cyc();
        check("sw_count", wq.size(), 2);
        check("sw_d0", qw(0), word(77));

        // Reset in the middle of a capture.
        do_arm(2'd0, 0, 0, 0);
        smp(1);
        fifo_busy = 1'b1;
        smp(2);
        fifo_busy = 1'b0;
        smp(3);
        check("mr_pre_ovf", overflow, 1);
        reset = 1'b1;
        smp(4);
        reset = 1'b0;
        check("mr_state", state, 0);
        check("mr_wr_en", fifo_wr_en, 0);
        check("mr_din", fifo_din, 0);
        check("mr_ww", words_written, 0);
        check("mr_done", done, 0);
        check("mr_ovf", overflow, 0);
        idle_cyc();

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
